// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters. Operands are latched at grant, and done follows grant by HOLD_CYCLES.
// Requests are sampled only in IDLE; a held request re-arbitrates after done. ALU_SHARE_STATS_EN adds the ops0/ops1 counters.
module alu_share_arbiter #(
  parameter int DATA_W      = 3,
  parameter int HOLD_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [1:0]        op0,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] b0,
  input  logic              req1,
  input  logic [1:0]        op1,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b1,
  output logic              grant0,
  output logic              grant1,
  output logic              done0,
  output logic              done1,
  output logic [DATA_W:0]   result,
  output logic              busy,
  output logic [1:0]        alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
`ifdef ALU_SHARE_STATS_EN
  input  logic [DATA_W:0]   alu_q,
  output logic [7:0]        ops0,
  output logic [7:0]        ops1
`else
  input  logic [DATA_W:0]   alu_q
`endif
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} stateT;

  localparam logic [3:0] CntLast = 4'(HOLD_CYCLES - 1);

  stateT      state;
  stateT      nextState;
  logic       rr;
  logic       owner;
  logic [3:0] cnt;
  logic       issueGo;
  logic       captureGo;
  logic       pick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    issueGo   = 1'b0;
    captureGo = 1'b0;
    pick      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          issueGo   = 1'b1;
          // rr only matters on contention; a lone requester always wins
          pick      = (req0 && req1) ? rr : req1;
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt == CntLast) begin
          captureGo = 1'b1;
          nextState = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    busy = (state == ISSUE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_sel <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      owner   <= 1'b0;
      rr      <= 1'b0;
      cnt     <= '0;
      grant0  <= 1'b0;
      grant1  <= 1'b0;
      done0   <= 1'b0;
      done1   <= 1'b0;
      result  <= '0;
    end else begin
      grant0 <= issueGo && !pick;
      grant1 <= issueGo && pick;
      done0  <= captureGo && !owner;
      done1  <= captureGo && owner;
      if (issueGo) begin
        alu_sel <= pick ? op1 : op0;
        alu_a   <= pick ? a1 : a0;
        alu_b   <= pick ? b1 : b0;
        owner   <= pick;
        rr      <= !pick;
        cnt     <= '0;
      end else if (state == ISSUE) begin
        cnt <= cnt + 4'd1;
      end
      if (captureGo) begin
        result <= alu_q;
      end
    end
  end

`ifdef ALU_SHARE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops0 <= '0;
      ops1 <= '0;
    end else begin
      if (captureGo && !owner && ops0 != 8'hFF) ops0 <= ops0 + 8'd1;
      if (captureGo && owner && ops1 != 8'hFF) ops1 <= ops1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench: two arbiter instances (HOLD_CYCLES 1 and 4), each driving a local ALU model.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  function automatic logic [3:0] aluf(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b);
    case (s)
      2'b00:   aluf = {1'b0, a} + {1'b0, b};
      2'b01:   aluf = {1'b0, a} - {1'b0, b};
      2'b10:   aluf = {1'b0, ~(a ^ b)};
      default: aluf = {2'b00, a[2:1]};
    endcase
  endfunction

  // Instance A, HOLD_CYCLES = 1
  logic       req0, req1, grant0, grant1, done0, done1, busy;
  logic [1:0] op0, op1, aluSel;
  logic [2:0] a0, b0, a1, b1, aluA, aluB;
  logic [3:0] result, aluQ;
  assign aluQ = aluf(aluSel, aluA, aluB);

  // Instance B, HOLD_CYCLES = 4
  logic       req0B, req1B, grant0B, grant1B, done0B, done1B, busyB;
  logic [1:0] op0B, op1B, aluSelB;
  logic [2:0] a0B, b0B, a1B, b1B, aluAB, aluBB;
  logic [3:0] resultB, aluQB;
  assign aluQB = aluf(aluSelB, aluAB, aluBB);

`ifdef ALU_SHARE_STATS_EN
  logic [7:0] ops0, ops1, ops0B, ops1B;
`endif

  alu_share_arbiter #(.DATA_W(3), .HOLD_CYCLES(1)) dutA (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1),
    .grant0(grant0), .grant1(grant1), .done0(done0), .done1(done1),
    .result(result), .busy(busy),
    .alu_sel(aluSel), .alu_a(aluA), .alu_b(aluB),
`ifdef ALU_SHARE_STATS_EN
    .alu_q(aluQ), .ops0(ops0), .ops1(ops1)
`else
    .alu_q(aluQ)
`endif
  );

  alu_share_arbiter #(.DATA_W(3), .HOLD_CYCLES(4)) dutB (
    .clk(clk), .rst_n(rst_n),
    .req0(req0B), .op0(op0B), .a0(a0B), .b0(b0B),
    .req1(req1B), .op1(op1B), .a1(a1B), .b1(b1B),
    .grant0(grant0B), .grant1(grant1B), .done0(done0B), .done1(done1B),
    .result(resultB), .busy(busyB),
    .alu_sel(aluSelB), .alu_a(aluAB), .alu_b(aluBB),
`ifdef ALU_SHARE_STATS_EN
    .alu_q(aluQB), .ops0(ops0B), .ops1(ops1B)
`else
    .alu_q(aluQB)
`endif
  );

  int nVec  = 0;
  int nMiss = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nVec++;
    assert (obs === exp)
    else begin
      nMiss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] expPair;
    rst_n = 1'b0;
    req0 = 0; op0 = 0; a0 = 0; b0 = 0; req1 = 0; op1 = 0; a1 = 0; b1 = 0;
    req0B = 0; op0B = 0; a0B = 0; b0B = 0; req1B = 0; op1B = 0; a1B = 0; b1B = 0;

    // Reset values
    @(negedge clk);
    check("rst_grant", 8'({grant1, grant0}), 8'd0);
    check("rst_done", 8'({done1, done0}), 8'd0);
    check("rst_busy", 8'(busy), 8'd0);
    check("rst_result", 8'(result), 8'd0);
    check("rst_alu", 8'({aluSel, aluA, aluB}), 8'd0);
    check("rst_busyB", 8'(busyB), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Requester 0 alone: 3 + 1
    req0 = 1; op0 = 2'b00; a0 = 3'b011; b0 = 3'b001;
    @(negedge clk);
    check("t1_grant0", 8'(grant0), 8'd1);
    check("t1_grant1", 8'(grant1), 8'd0);
    check("t1_busy", 8'(busy), 8'd1);
    check("t1_done0_early", 8'(done0), 8'd0);
    check("t1_alu_sel", 8'(aluSel), 8'd0);
    check("t1_alu_a", 8'(aluA), 8'd3);
    req0 = 0;
    @(negedge clk);
    check("t1_done0", 8'(done0), 8'd1);
    check("t1_grant0_drop", 8'(grant0), 8'd0);
    check("t1_busy_drop", 8'(busy), 8'd0);
    check("t1_result", 8'(result), 8'h4);
    @(negedge clk);
    check("t1_done0_pulse", 8'(done0), 8'd0);
    check("t1_result_hold", 8'(result), 8'h4);

    // Requester 1 alone: 4 + 7 carries into bit 3
    req1 = 1; op1 = 2'b00; a1 = 3'b100; b1 = 3'b111;
    @(negedge clk);
    check("t2_grant1", 8'(grant1), 8'd1);
    check("t2_grant0", 8'(grant0), 8'd0);
    req1 = 0;
    @(negedge clk);
    check("t2_done1", 8'(done1), 8'd1);
    check("t2_done0", 8'(done0), 8'd0);
    check("t2_result", 8'(result), 8'hB);

    // Both requesting from reset: grants alternate 0,1,0,1...
    rst_n = 1'b0;
    req0 = 1; op0 = 2'b01; a0 = 3'b100; b0 = 3'b001;
    req1 = 1; op1 = 2'b11; a1 = 3'b101; b1 = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      expPair = (i % 2 == 1) ? 2'b10 : 2'b01;
      @(negedge clk);
      check("rr_grant", 8'({grant1, grant0}), 8'(expPair));
      check("rr_nodone", 8'({done1, done0}), 8'd0);
      @(negedge clk);
      check("rr_done", 8'({done1, done0}), 8'(expPair));
      check("rr_result", 8'(result), (i % 2 == 1) ? 8'h2 : 8'h3);
    end

    // Abort requester 0's grant with an async reset; rr must return to 0
    @(negedge clk);
    check("ab_grant0", 8'(grant0), 8'd1);
    rst_n = 1'b0;
    #1;
    check("ab_async_grant", 8'({grant1, grant0}), 8'd0);
    check("ab_async_busy", 8'(busy), 8'd0);
    check("ab_async_result", 8'(result), 8'd0);
    check("ab_async_alu", 8'({aluSel, aluA, aluB}), 8'd0);
    @(negedge clk);
    check("ab_nodone_rst", 8'({done1, done0}), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ab_regrant", 8'({grant1, grant0}), 8'b01);
    check("ab_nodone", 8'({done1, done0}), 8'd0);
    req1 = 0;
    @(negedge clk);
    check("ab_done0", 8'({done1, done0}), 8'b01);
    check("ab_result", 8'(result), 8'h3);
    req0 = 0;

`ifdef ALU_SHARE_STATS_EN
    // 270 more requester-0 ops on top of the one above: counter must saturate
    @(negedge clk);
    req0 = 1;
    repeat (540) @(negedge clk);
    req0 = 0;
    repeat (3) @(negedge clk);
    check("st_ops0", ops0, 8'd255);
    check("st_ops1", ops1, 8'd0);
`endif

    // HOLD_CYCLES = 4: 3 + 2
    @(negedge clk);
    req0B = 1; op0B = 2'b00; a0B = 3'b011; b0B = 3'b010;
    @(negedge clk);
    check("h4a_grant0", 8'(grant0B), 8'd1);
    check("h4a_busy", 8'(busyB), 8'd1);
    req0B = 0;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("h4a_busy_hold", 8'(busyB), 8'd1);
      check("h4a_nodone", 8'({done1B, done0B, grant1B, grant0B}), 8'd0);
    end
    @(negedge clk);
    check("h4a_done0", 8'(done0B), 8'd1);
    check("h4a_busy_drop", 8'(busyB), 8'd0);
    check("h4a_result", 8'(resultB), 8'h5);

    // 7 - 7 with operands disturbed right after the grant
    @(negedge clk);
    req0B = 1; op0B = 2'b01; a0B = 3'b111; b0B = 3'b111;
    @(negedge clk);
    check("h4b_grant0", 8'(grant0B), 8'd1);
    req0B = 0; op0B = 2'b00; a0B = 3'b011; b0B = 3'b000;
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      check("h4b_busy_hold", 8'(busyB), 8'd1);
      check("h4b_nodone", 8'(done0B), 8'd0);
    end
    @(negedge clk);
    check("h4b_done0", 8'(done0B), 8'd1);
    check("h4b_result", 8'(resultB), 8'h0);
    check("h4b_alu_sel", 8'(aluSelB), 8'd1);
`ifdef ALU_SHARE_STATS_EN
    check("h4_ops0", ops0B, 8'd2);
    check("h4_ops1", ops1B, 8'd0);
`endif
    @(negedge clk);
    check("h4b_done0_pulse", 8'(done0B), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
